// File: rtl/ame_num_accum_if.sv
// Operand/result bundle between the dot-product feeder and the accumulator.
// The feeder drives operands through master; the accumulator returns results through slave.
interface ame_num_accum_if #(
  parameter int IN_DATA_BITS   = 24,
  parameter int COMP_DATA_BITS = 64,
  parameter int CNT_BITS       = 16
);
  logic                      comp_init_i;
  logic                      comp_valid_i;
  logic                      comp_last_i;
  logic [IN_DATA_BITS-1:0]   comp_data_a_i;
  logic [IN_DATA_BITS-1:0]   comp_data_b_i;
  logic [COMP_DATA_BITS-1:0] comp_data_o;
  logic [CNT_BITS-1:0]       comp_count_o;
  logic                      comp_sat_o;
  logic                      comp_done_o;

  modport master (
    output comp_init_i, comp_valid_i, comp_last_i, comp_data_a_i, comp_data_b_i,
    input  comp_data_o, comp_count_o, comp_sat_o, comp_done_o
  );

  modport slave (
    input  comp_init_i, comp_valid_i, comp_last_i, comp_data_a_i, comp_data_b_i,
    output comp_data_o, comp_count_o, comp_sat_o, comp_done_o
  );
endinterface

// File: rtl/ame_num_accum.sv
// Saturating signed multiply-accumulate: stage 1 multiplies, stage 2 accumulates,
// and the result registers update once per completed sum.
// state | meaning
// IDLE  | waiting for comp_init_i, pairs ignored
// ACCUM | accepting operand pairs
// FLUSH | last pair in the pipeline, waiting for the result to land
module ame_num_accum #(
  parameter int IN_DATA_BITS   = 24,
  parameter int COMP_DATA_BITS = 64,
  parameter int CNT_BITS       = 16
) (
  input logic           clk_i,
  input logic           rst_n_i,
  ame_num_accum_if.slave bus
);
  localparam int PROD_BITS = 2 * IN_DATA_BITS;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t state, state_nxt;

  logic                             accept;
  logic signed [IN_DATA_BITS-1:0]   a, b;
  logic signed [PROD_BITS-1:0]      prod;
  logic                             p1_valid, p1_last;
  logic signed [PROD_BITS-1:0]      p1_prod;
  logic                             p2_last;
  logic signed [COMP_DATA_BITS-1:0] acc, ext, sum, sum_sat;
  logic                             ovf, sat;
  logic [CNT_BITS-1:0]              cnt;

  assign a      = $signed(bus.comp_data_a_i);
  assign b      = $signed(bus.comp_data_b_i);
  assign prod   = PROD_BITS'(a) * PROD_BITS'(b);
  // init with valid accepts the pair as the first term of the new sum
  assign accept = bus.comp_valid_i && (bus.comp_init_i || state == ACCUM);

  assign ext = COMP_DATA_BITS'(p1_prod);
  assign sum = acc + ext;
  assign ovf = (acc[COMP_DATA_BITS-1] == ext[COMP_DATA_BITS-1]) &&
               (sum[COMP_DATA_BITS-1] != acc[COMP_DATA_BITS-1]);

  always_comb begin
    sum_sat = sum;
    if (ovf) begin
      sum_sat = acc[COMP_DATA_BITS-1] ? {1'b1, {(COMP_DATA_BITS-1){1'b0}}}
                                      : {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.comp_init_i) begin
      state_nxt = (accept && bus.comp_last_i) ? FLUSH : ACCUM;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (accept && bus.comp_last_i) state_nxt = FLUSH;
        FLUSH:   if (p2_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage 1 is reloaded every edge, so an init flushes whatever was in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p1_prod  <= '0;
    end else begin
      p1_valid <= accept;
      p1_last  <= accept && bus.comp_last_i;
      if (accept) p1_prod <= prod;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      p2_last <= 1'b0;
    end else if (bus.comp_init_i) begin
      acc     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      p2_last <= 1'b0;
    end else begin
      p2_last <= 1'b0;
      if (p1_valid) begin
        acc     <= sum_sat;
        sat     <= sat | ovf;
        cnt     <= (&cnt) ? cnt : cnt + CNT_BITS'(1);
        p2_last <= p1_last;
      end
    end
  end

  // Result registers only move on completion, so partial sums never leak out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.comp_data_o  <= '0;
      bus.comp_count_o <= '0;
      bus.comp_sat_o   <= 1'b0;
      bus.comp_done_o  <= 1'b0;
    end else if (p2_last && !bus.comp_init_i) begin
      bus.comp_data_o  <= acc;
      bus.comp_count_o <= cnt;
      bus.comp_sat_o   <= sat;
      bus.comp_done_o  <= 1'b1;
    end else begin
      bus.comp_done_o  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ame_num_accum.sv
// Directed bench: a default-width instance plus a 48-bit / 2-bit-counter
// instance for saturation corners.
module tb_ame_num_accum;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ame_num_accum_if #(.IN_DATA_BITS(24), .COMP_DATA_BITS(64), .CNT_BITS(16)) b1 ();
  ame_num_accum_if #(.IN_DATA_BITS(24), .COMP_DATA_BITS(48), .CNT_BITS(2))  b2 ();

  ame_num_accum #(.IN_DATA_BITS(24), .COMP_DATA_BITS(64), .CNT_BITS(16)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b1));
  ame_num_accum #(.IN_DATA_BITS(24), .COMP_DATA_BITS(48), .CNT_BITS(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b2));

  task automatic send1(input logic i, input logic v, input logic l, input int a, input int b);
    b1.comp_init_i = i; b1.comp_valid_i = v; b1.comp_last_i = l;
    b1.comp_data_a_i = a[23:0]; b1.comp_data_b_i = b[23:0];
    @(posedge clk); #1;
    b1.comp_init_i = 1'b0; b1.comp_valid_i = 1'b0; b1.comp_last_i = 1'b0;
  endtask

  task automatic send2(input logic i, input logic v, input logic l, input int a, input int b);
    b2.comp_init_i = i; b2.comp_valid_i = v; b2.comp_last_i = l;
    b2.comp_data_a_i = a[23:0]; b2.comp_data_b_i = b[23:0];
    @(posedge clk); #1;
    b2.comp_init_i = 1'b0; b2.comp_valid_i = 1'b0; b2.comp_last_i = 1'b0;
  endtask

  // Bubble with junk operands and last set: must be ignored because valid is low.
  task automatic bubble1();
    b1.comp_valid_i = 1'b0; b1.comp_last_i = 1'b1;
    b1.comp_data_a_i = 24'd77; b1.comp_data_b_i = 24'd77;
    @(posedge clk); #1;
    b1.comp_last_i = 1'b0;
  endtask

  // Returns the number of rising edges after the last pair's edge until done is seen.
  task automatic wait_done1(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (b1.comp_done_o) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (b2.comp_done_o) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b1.comp_init_i = 0; b1.comp_valid_i = 0; b1.comp_last_i = 0; b1.comp_data_a_i = 0; b1.comp_data_b_i = 0;
    b2.comp_init_i = 0; b2.comp_valid_i = 0; b2.comp_last_i = 0; b2.comp_data_a_i = 0; b2.comp_data_b_i = 0;
    repeat (3) @(negedge clk);
    tests++; if (b1.comp_data_o !== 64'd0) begin fails++; $display("FAIL reset_data1: got %0h expected 0", b1.comp_data_o); end
    tests++; if (b1.comp_count_o !== 16'd0) begin fails++; $display("FAIL reset_count1: got %0d expected 0", b1.comp_count_o); end
    tests++; if (b1.comp_sat_o !== 1'b0 || b1.comp_done_o !== 1'b0) begin fails++; $display("FAIL reset_flags1: got sat=%b done=%b expected 0 0", b1.comp_sat_o, b1.comp_done_o); end
    tests++; if (b2.comp_data_o !== 48'd0 || b2.comp_done_o !== 1'b0) begin fails++; $display("FAIL reset_inst2: got data=%0h done=%b expected 0 0", b2.comp_data_o, b2.comp_done_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    logic signed [63:0] e = -64'sd99;
    send1(1, 0, 0, 0, 0);
    send1(0, 1, 0, 3, 5);
    send1(0, 1, 0, -2, 7);
    send1(0, 1, 0, 100, -1);
    send1(0, 1, 1, 0, 9);
    wait_done1(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL b2b_latency: got %0d edges expected 2", n); end
    tests++; if (b1.comp_data_o !== e) begin fails++; $display("FAIL b2b_data: got %0d expected -99", $signed(b1.comp_data_o)); end
    tests++; if (b1.comp_count_o !== 16'd4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", b1.comp_count_o); end
    tests++; if (b1.comp_sat_o !== 1'b0) begin fails++; $display("FAIL b2b_sat: got %b expected 0", b1.comp_sat_o); end
    @(posedge clk); @(negedge clk);
    tests++; if (b1.comp_done_o !== 1'b0) begin fails++; $display("FAIL b2b_done_width: got %b expected 0", b1.comp_done_o); end
    repeat (3) @(negedge clk);
    tests++; if (b1.comp_data_o !== e) begin fails++; $display("FAIL b2b_hold: got %0d expected -99", $signed(b1.comp_data_o)); end
  endtask

  task automatic test_bubbles();
    int n;
    logic signed [63:0] e = -64'sd99;
    send1(1, 0, 0, 0, 0);
    send1(0, 1, 0, 3, 5);   bubble1();
    send1(0, 1, 0, -2, 7);  bubble1(); bubble1();
    @(negedge clk);
    tests++; if (b1.comp_data_o !== e) begin fails++; $display("FAIL bub_no_partial: got %0d expected -99", $signed(b1.comp_data_o)); end
    send1(0, 1, 0, 100, -1); bubble1();
    send1(0, 1, 1, 0, 9);
    wait_done1(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL bub_latency: got %0d edges expected 2", n); end
    tests++; if (b1.comp_data_o !== e || b1.comp_count_o !== 16'd4) begin fails++; $display("FAIL bub_result: got %0d/%0d expected -99/4", $signed(b1.comp_data_o), b1.comp_count_o); end
  endtask

  task automatic test_idle_ignore();
    int seen = 0;
    logic signed [63:0] e = -64'sd99;
    send1(0, 1, 1, 50, 50);
    repeat (6) begin @(negedge clk); if (b1.comp_done_o) seen++; end
    tests++; if (seen !== 0 || b1.comp_data_o !== e) begin fails++; $display("FAIL idle_ignore: got done=%0d data=%0d expected 0 -99", seen, $signed(b1.comp_data_o)); end
  endtask

  task automatic test_single_term();
    int n;
    logic signed [63:0] e = -64'sd42;
    send1(1, 1, 1, -7, 6);
    wait_done1(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL single_latency: got %0d edges expected 2", n); end
    tests++; if (b1.comp_data_o !== e || b1.comp_count_o !== 16'd1) begin fails++; $display("FAIL single_result: got %0d/%0d expected -42/1", $signed(b1.comp_data_o), b1.comp_count_o); end
  endtask

  task automatic test_abort();
    int n;
    int seen = 0;
    send1(1, 0, 0, 0, 0);
    send1(0, 1, 0, 10, 10);
    send1(0, 1, 0, 10, 10);
    send1(0, 1, 0, 10, 10);
    send1(1, 0, 0, 0, 0);
    send1(0, 1, 0, 1, 1);
    send1(0, 1, 1, 2, 2);
    wait_done1(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL abort_latency: got %0d edges expected 2", n); end
    tests++; if (b1.comp_data_o !== 64'd5 || b1.comp_count_o !== 16'd2) begin fails++; $display("FAIL abort_result: got %0d/%0d expected 5/2", $signed(b1.comp_data_o), b1.comp_count_o); end
    repeat (6) begin @(negedge clk); if (b1.comp_done_o) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_extra_done: got %0d pulses expected 0", seen); end
    send1(1, 1, 1, 5, 5);
    send1(1, 1, 1, 3, 3);
    wait_done1(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL flush_abort_latency: got %0d edges expected 2", n); end
    tests++; if (b1.comp_data_o !== 64'd9 || b1.comp_count_o !== 16'd1) begin fails++; $display("FAIL flush_abort_result: got %0d/%0d expected 9/1", $signed(b1.comp_data_o), b1.comp_count_o); end
  endtask

  task automatic test_saturation();
    int n;
    logic signed [47:0] e;
    e = {1'b0, {47{1'b1}}};
    send2(1, 0, 0, 0, 0);
    send2(0, 1, 0, -8388608, -8388608);
    send2(0, 1, 1, -8388608, -8388608);
    wait_done2(n);
    tests++; if (n !== 2) begin fails++; $display("FAIL pos_sat_latency: got %0d edges expected 2", n); end
    tests++; if (b2.comp_data_o !== e || b2.comp_sat_o !== 1'b1) begin fails++; $display("FAIL pos_sat: got %0h sat=%b expected %0h sat=1", b2.comp_data_o, b2.comp_sat_o, e); end
    e = {1'b1, {47{1'b0}}};
    send2(1, 1, 0, -8388608, 8388607);
    send2(0, 1, 0, -8388608, 8388607);
    send2(0, 1, 1, -8388608, 8388607);
    wait_done2(n);
    tests++; if (b2.comp_data_o !== e || b2.comp_sat_o !== 1'b1 || b2.comp_count_o !== 2'd3) begin fails++; $display("FAIL neg_sat: got %0h sat=%b cnt=%0d expected %0h sat=1 cnt=3", b2.comp_data_o, b2.comp_sat_o, b2.comp_count_o, e); end
  endtask

  task automatic test_count_sat();
    int n;
    send2(1, 0, 0, 0, 0);
    repeat (4) send2(0, 1, 0, 1, 1);
    send2(0, 1, 1, 1, 1);
    wait_done2(n);
    tests++; if (b2.comp_count_o !== 2'd3) begin fails++; $display("FAIL count_sat: got %0d expected 3", b2.comp_count_o); end
    tests++; if (b2.comp_data_o !== 48'd5 || b2.comp_sat_o !== 1'b0) begin fails++; $display("FAIL count_sat_data: got %0d sat=%b expected 5 sat=0", b2.comp_data_o, b2.comp_sat_o); end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    send2(1, 1, 1, 1000, 1000);
    send1(1, 0, 0, 0, 0);
    send1(0, 1, 0, 4, 4);
    send1(0, 1, 1, 5, 5);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (b1.comp_data_o !== 64'd0 || b1.comp_count_o !== 16'd0) begin fails++; $display("FAIL async_rst_data: got %0d/%0d expected 0/0", $signed(b1.comp_data_o), b1.comp_count_o); end
    tests++; if (b1.comp_done_o !== 1'b0 || b1.comp_sat_o !== 1'b0) begin fails++; $display("FAIL async_rst_flags: got done=%b sat=%b expected 0 0", b1.comp_done_o, b1.comp_sat_o); end
    tests++; if (b2.comp_data_o !== 48'd0 || b2.comp_count_o !== 2'd0) begin fails++; $display("FAIL async_rst_inst2: got %0d/%0d expected 0/0", b2.comp_data_o, b2.comp_count_o); end
    #1 rst_n = 1'b1;
    repeat (8) begin @(negedge clk); if (b1.comp_done_o || b2.comp_done_o) seen++; end
    tests++; if (seen !== 0 || b1.comp_data_o !== 64'd0) begin fails++; $display("FAIL async_rst_no_done: got %0d pulses data=%0d expected 0 0", seen, $signed(b1.comp_data_o)); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_idle_ignore();
    test_single_term();
    test_abort();
    test_saturation();
    test_count_sat();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
